// File: rtl/cmd_queue_pkg.sv
// rtl/cmd_queue_pkg.sv - shared opcodes, word-0 layout, FSM states and command record for cmd_queue
// Contents:
//   OP_*        op_type codes driven to the scheduler
//   W0_*        bit positions of the fields packed into command word 0
//   IDLE/ISSUE/WAIT  issue FSM state encodings
//   cmd_t       buffered command record; CMD_W is its width
//   op_is_legal true for the opcodes the scheduler understands
package cmd_queue_pkg;

  localparam logic [2:0] OP_IDLE   = 3'd0;
  localparam logic [2:0] OP_CONV1  = 3'd1;
  localparam logic [2:0] OP_CONV3  = 3'd2;
  localparam logic [2:0] OP_POOL3  = 3'd3;
  localparam logic [2:0] OP_POOL13 = 3'd4;

  localparam int W0_OP_LSB     = 0;
  localparam int W0_OP_MSB     = 2;
  localparam int W0_STRIDE_LSB = 4;
  localparam int W0_STRIDE_MSB = 7;
  localparam int W0_KERNEL_LSB = 8;
  localparam int W0_KERNEL_MSB = 11;
  localparam int W0_PAD_LSB    = 12;
  localparam int W0_PAD_MSB    = 15;
  localparam int W0_OC_LSB     = 16;
  localparam int W0_OC_MSB     = 31;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // Only the 31 meaningful bits of word 0 are kept (bit 3 is a spare), so
  // the record is 31 + 3*32 bits.
  typedef struct packed {
    logic [2:0]  op_type;
    logic [3:0]  stride;
    logic [3:0]  kernel;
    logic [3:0]  pad;
    logic [15:0] oc;
    logic [31:0] src_addr;
    logic [31:0] wgt_addr;
    logic [31:0] dst_addr;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      OP_IDLE:                                 return 1'b0;
      OP_CONV1, OP_CONV3, OP_POOL3, OP_POOL13: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous FIFO of whole command records
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write request and record (ignored when full)
//   pop, pop_data       read request (ignored when empty); pop_data is the head
//   count               records held
//   full, empty         occupancy flags
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cmd_queue.sv
// rtl/cmd_queue.sv - assembles 4-word commands from pipe-in, queues them, issues one at a time
// Build option: CMDQ_ILLEGAL_CHECK_EN drops commands with an unknown opcode and adds err_illegal.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_data/in_valid/in_ready  32-bit pipe-in word stream
//   op_type, op_issue      opcode and one-cycle start pulse to the scheduler
//   op_stride/kernel/pad/oc, op_src/wgt/dst_addr  operands, held until the next issue
//   op_done                completion pulse from the scheduler
//   busy                   a command is being issued or executed
//   cmd_count              commands waiting in the FIFO
//   err_illegal            sticky illegal-opcode flag (option only)
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       op_type,
  output logic             op_issue,
  output logic [3:0]       op_stride,
  output logic [3:0]       op_kernel,
  output logic [3:0]       op_pad,
  output logic [15:0]      op_oc,
  output logic [31:0]      op_src_addr,
  output logic [31:0]      op_wgt_addr,
  output logic [31:0]      op_dst_addr,
  input  logic             op_done,
  output logic             busy,
  output logic [CNT_W-1:0] cmd_count
`ifdef CMDQ_ILLEGAL_CHECK_EN
  ,
  output logic             err_illegal
`endif
);

  logic [1:0]  idx_q, idx_d;
  logic [30:0] hdr_q, hdr_d;
  logic [31:0] src_q, src_d;
  logic [31:0] wgt_q, wgt_d;
  logic [1:0]  state_q, state_d;
  cmd_t        op_q, op_d;
  cmd_t        head;
  logic        hs, push, pop, fifo_full, fifo_empty;

  // Held low through reset so nothing is accepted while the queue is cleared.
  assign in_ready = !rst && !fifo_full;
  assign hs       = in_valid && in_ready;

  // Word assembler: w0..w2 go to staging, w3 completes the record.
  always_comb begin
    idx_d = idx_q;
    hdr_d = hdr_q;
    src_d = src_q;
    wgt_d = wgt_q;
    if (hs) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0: hdr_d = {in_data[W0_OP_MSB:W0_OP_LSB], in_data[W0_STRIDE_MSB:W0_STRIDE_LSB],
                       in_data[W0_KERNEL_MSB:W0_KERNEL_LSB], in_data[W0_PAD_MSB:W0_PAD_LSB],
                       in_data[W0_OC_MSB:W0_OC_LSB]};
        2'd1: src_d = in_data;
        2'd2: wgt_d = in_data;
        default: ;
      endcase
    end
  end

`ifdef CMDQ_ILLEGAL_CHECK_EN
  logic drop_q, drop_d;
  logic err_q, err_d;

  // The verdict is taken on w0 and suppresses the push three words later.
  always_comb begin
    drop_d = drop_q;
    err_d  = err_q;
    if (hs && idx_q == 2'd0) begin
      drop_d = !op_is_legal(in_data[W0_OP_MSB:W0_OP_LSB]);
      err_d  = err_q || drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  assign push        = hs && idx_q == 2'd3 && !drop_q;
  assign err_illegal = err_q;
`else
  assign push = hs && idx_q == 2'd3;
`endif

  // Issue FSM: the head is latched on the IDLE->ISSUE edge so operands are
  // already valid while op_issue is high; the FIFO entry is freed in ISSUE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = ISSUE;
          op_d    = head;
        end
      end
      ISSUE: begin
        pop     = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (op_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 2'd0;
      hdr_q   <= '0;
      src_q   <= '0;
      wgt_q   <= '0;
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      src_q   <= src_d;
      wgt_q   <= wgt_d;
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .W     (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({hdr_q, src_q, wgt_q, in_data}),
    .pop       (pop),
    .pop_data  (head),
    .count     (cmd_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign op_issue    = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign op_type     = op_q.op_type;
  assign op_stride   = op_q.stride;
  assign op_kernel   = op_q.kernel;
  assign op_pad      = op_q.pad;
  assign op_oc       = op_q.oc;
  assign op_src_addr = op_q.src_addr;
  assign op_wgt_addr = op_q.wgt_addr;
  assign op_dst_addr = op_q.dst_addr;

endmodule
